// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the KGP-RISC datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, memory handshake with timeout, HALT and illegal-opcode/timeout traps.
module multicycle_control #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned BR_W    = 2,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned MTR_W   = 2,
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TIMEOUT = 12,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic               stall,
  input  logic               restart,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [BR_W-1:0]    branch,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src,
  output logic               reg_dest,
  output logic               reg_write,
  output logic [MTR_W-1:0]   mem_to_reg,
  output logic [2:0]         state,
  output logic               halted,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef struct packed {
    logic [BR_W-1:0]    branch;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               reg_dest;
    logic [MTR_W-1:0]   mtr;
    logic               is_br;
    logic               is_link;
    logic               is_load;
    logic               is_store;
  } ctl_t;

  localparam logic [OP_W-1:0] OP_R0   = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_R1   = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_R2   = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_BR1  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BR2  = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h06);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_I0   = OP_W'(6'h24);
  localparam logic [OP_W-1:0] OP_I1   = OP_W'(6'h25);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'h3F);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TMO     = 2'b10;

  state_t           state_q, state_d;
  ctl_t             ctl_q, ctl_d, dec;
  logic             dec_halt, dec_illegal;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             ret_inc;
  logic             mem_req_q, mem_we_q, i_or_d_q, halted_q, trap_q;

  // Opcode decode; only captured while sitting in DECODE.
  always_comb begin
    dec         = '0;
    dec_halt    = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      OP_R0:   dec.alu_op = ALUOP_W'(0);
      OP_R1:   dec.alu_op = ALUOP_W'(1);
      OP_R2:   dec.alu_op = ALUOP_W'(2);
      OP_BR1, OP_BR2, OP_JAL: begin
        dec.is_br   = 1'b1;
        dec.alu_op  = ALUOP_W'(3);
        dec.alu_src = 1'b1;
        dec.branch  = (opcode == OP_BR1) ? BR_W'(1) :
                      (opcode == OP_BR2) ? BR_W'(2) : BR_W'(3);
        if (opcode == OP_JAL) begin
          dec.is_link  = 1'b1;
          dec.reg_dest = 1'b1;
          dec.mtr      = MTR_W'(1);
        end
      end
      OP_LD: begin
        dec.is_load  = 1'b1;
        dec.alu_op   = ALUOP_W'(4);
        dec.alu_src  = 1'b1;
        dec.reg_dest = 1'b1;
        dec.mtr      = MTR_W'(2);
      end
      OP_ST: begin
        dec.is_store = 1'b1;
        dec.alu_op   = ALUOP_W'(4);
        dec.alu_src  = 1'b1;
      end
      OP_I0, OP_I1: begin
        dec.alu_op  = (opcode == OP_I0) ? ALUOP_W'(4) : ALUOP_W'(5);
        dec.alu_src = 1'b1;
      end
      OP_HALT: dec_halt = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
  end

  // Next-state, wait counter, trap cause and single-cycle pulses.
  always_comb begin
    state_d       = state_q;
    ctl_d         = ctl_q;
    tmo_d         = tmo_q;
    cause_d       = cause_q;
    ret_inc       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    if (!stall) begin
      case (state_q)
        S_FETCH, S_MEM: begin
          if (mem_req_q) begin
            if (mem_ready) begin
              if (state_q == S_FETCH) begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                state_d  = S_DECODE;
              end else if (ctl_q.is_load) begin
                state_d = S_WB;
              end else begin
                state_d = S_FETCH;
                ret_inc = 1'b1;
              end
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
              state_d = S_TRAP;
              cause_d = CAUSE_TMO;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
        end
        S_DECODE: begin
          ctl_d = dec;
          if (dec_halt) begin
            state_d = S_HALT;
          end else if (dec_illegal) begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (ctl_q.is_br) begin
            pc_write_cond = 1'b1;
            if (ctl_q.is_link) begin
              state_d = S_WB;
            end else begin
              state_d = S_FETCH;
              ret_inc = 1'b1;
            end
          end else if (ctl_q.is_load || ctl_q.is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
          ret_inc   = 1'b1;
        end
        S_HALT, S_TRAP: begin
          if (restart) begin
            state_d = S_FETCH;
            cause_d = 2'b00;
          end
        end
        default: state_d = S_FETCH;
      endcase
      if (state_d != state_q) tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ctl_q     <= '0;
      tmo_q     <= '0;
      cause_q   <= 2'b00;
      retired_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      i_or_d_q  <= 1'b0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= ctl_d;
      tmo_q     <= tmo_d;
      cause_q   <= cause_d;
      if (ret_inc) retired_q <= retired_q + CNT_W'(1);
      mem_req_q <= (state_d == S_FETCH) || (state_d == S_MEM);
      mem_we_q  <= (state_d == S_MEM) && ctl_d.is_store;
      i_or_d_q  <= (state_d == S_MEM);
      halted_q  <= (state_d == S_HALT);
      trap_q    <= (state_d == S_TRAP);
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign i_or_d     = i_or_d_q;
  assign branch     = ctl_q.branch;
  assign alu_op     = ctl_q.alu_op;
  assign alu_src    = ctl_q.alu_src;
  assign reg_dest   = ctl_q.reg_dest;
  assign mem_to_reg = ctl_q.mtr;
  assign state      = state_q;
  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: instruction flows, HALT/TRAP, timeouts,
// stall priority and asynchronous reset.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n, stall, restart, mem_ready;
  logic [5:0]  opcode;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  branch, mem_to_reg, trap_cause;
  logic [2:0]  alu_op, state;
  logic        alu_src, reg_dest, reg_write, halted, trap;
  logic [15:0] retired;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .stall(stall), .restart(restart),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch(branch), .alu_op(alu_op), .alu_src(alu_src), .reg_dest(reg_dest),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state), .halted(halted),
    .trap(trap), .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete a FETCH handshake for op and land in DECODE.
  task automatic fetch(input logic [5:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    check("fetch_state", 32'(state), 0);
    check("fetch_req", 32'(mem_req), 1);
    check("ir_write", 32'(ir_write), 1);
    check("pc_write", 32'(pc_write), 1);
    tick();
    mem_ready = 1'b0;
    #1;
    check("decode_state", 32'(state), 1);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; restart = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_halt_trap", {30'd0, halted, trap}, 0);
    rst_n = 1'b1;
    tick();
    check("fetch_req_after_rst", {29'd0, mem_req, i_or_d, mem_we}, 32'b100);

    // R-type 01; restart in DECODE is ignored
    fetch(6'h01);
    restart = 1'b1;
    tick(); restart = 1'b0;
    check("r_exec", 32'(state), 2);
    check("r_aluop", {28'd0, alu_op, alu_src}, 0);
    tick();
    check("r_wb", 32'(state), 4);
    check("r_regwr", 32'(reg_write), 1);
    check("r_ret_pre", 32'(retired), 0);
    tick();
    check("r_back_fetch", 32'(state), 0);
    check("r_retired", 32'(retired), 1);

    // Load 23 with three wait cycles in MEM
    fetch(6'h23);
    tick();
    check("ld_exec", {28'd0, alu_op, alu_src}, {28'd0, 3'd4, 1'b1});
    tick();
    check("ld_mem", 32'(state), 3);
    for (int i = 0; i < 3; i++) begin
      check("ld_wait_bus", {30'd0, mem_req, i_or_d}, 3);
      tick();
    end
    mem_ready = 1'b1; #1;
    check("ld_last_bus", {29'd0, mem_req, i_or_d, mem_we}, 32'b110);
    tick(); mem_ready = 1'b0;
    check("ld_wb", 32'(state), 4);
    check("ld_wb_ctl", {28'd0, mem_to_reg, reg_dest, reg_write}, {28'd0, 2'b10, 1'b1, 1'b1});
    check("ld_wb_noreq", 32'(mem_req), 0);
    tick();
    check("ld_retired", 32'(retired), 2);

    // Store 2B
    fetch(6'h2B);
    tick(); tick();
    check("st_mem_bus", {29'd0, mem_req, i_or_d, mem_we}, 32'b111);
    mem_ready = 1'b1; #1;
    check("st_no_regwr", 32'(reg_write), 0);
    tick(); mem_ready = 1'b0;
    check("st_fetch", {29'd0, state}, 0);
    check("st_we_off", 32'(mem_we), 0);
    check("st_retired", 32'(retired), 3);

    // Link branch 06
    fetch(6'h06);
    tick();
    check("jal_pcwc", {30'd0, pc_write_cond, reg_write}, 32'b10);
    check("jal_branch", 32'(branch), 3);
    tick();
    check("jal_wb", {27'd0, state, reg_write, reg_dest}, {27'd0, 3'd4, 1'b1, 1'b1});
    check("jal_mtr", 32'(mem_to_reg), 1);
    tick();
    check("jal_retired", 32'(retired), 4);

    // Conditional branch 04 retires straight from EXEC
    fetch(6'h04);
    tick();
    check("br_pcwc", 32'(pc_write_cond), 1);
    check("br_branch", 32'(branch), 1);
    tick();
    check("br_fetch", 32'(state), 0);
    check("br_retired", 32'(retired), 5);

    // HALT and restart
    fetch(6'h3F);
    tick();
    check("halt_state", {29'd0, state}, 5);
    check("halted", {30'd0, halted, mem_req}, 32'b10);
    tick();
    check("halt_hold", 32'(halted), 1);
    restart = 1'b1;
    tick(); restart = 1'b0;
    check("halt_restart", {30'd0, state[1:0] == 2'b00, halted}, 32'b10);
    check("halt_retired", 32'(retired), 5);

    // Illegal opcode 07
    fetch(6'h07);
    tick();
    check("ill_trap", {27'd0, state, trap, trap_cause}, {27'd0, 3'd6, 1'b1, 2'b01});
    tick();
    check("ill_hold", 32'(trap), 1);
    restart = 1'b1;
    tick(); restart = 1'b0;
    check("ill_restart", {27'd0, state, trap, trap_cause}, 0);

    // MEM timeout: exactly 12 cycles in MEM
    fetch(6'h23);
    tick(); tick();
    check("tmo_mem", 32'(state), 3);
    repeat (11) tick();
    check("tmo_still_mem", 32'(state), 3);
    tick();
    check("tmo_trap", {27'd0, state, trap, trap_cause}, {27'd0, 3'd6, 1'b1, 2'b10});
    restart = 1'b1; tick(); restart = 1'b0;

    // MEM timeout extended by 5 stalled cycles, ready ignored while stalled
    fetch(6'h23);
    tick(); tick();
    repeat (5) tick();
    stall = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_bus", {29'd0, mem_req, i_or_d, reg_write}, 32'b110);
      tick();
    end
    stall = 1'b0; mem_ready = 1'b0;
    repeat (6) tick();
    check("stmo_still_mem", 32'(state), 3);
    tick();
    check("stmo_trap", {29'd0, trap, trap_cause}, 32'b110);
    restart = 1'b1; tick(); restart = 1'b0;

    // Stalled FETCH with ready: no pulses, no advance
    stall = 1'b1; mem_ready = 1'b1; opcode = 6'h01; #1;
    check("stall_fetch_pulse", {30'd0, ir_write, pc_write}, 0);
    tick();
    check("stall_fetch_hold", 32'(state), 0);
    stall = 1'b0; mem_ready = 1'b0;

    // Asynchronous reset while in MEM
    fetch(6'h23);
    tick(); tick();
    check("arst_pre", 32'(state), 3);
    #1 rst_n = 1'b0; #1;
    check("arst_state", {29'd0, state}, 0);
    check("arst_bus", {29'd0, mem_req, i_or_d, mem_we}, 0);
    check("arst_ctl", {27'd0, alu_op, alu_src, reg_dest}, 0);
    check("arst_retired", 32'(retired), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Stall with ready in WB suppresses reg_write until released
    fetch(6'h01);
    tick(); tick();
    stall = 1'b1; mem_ready = 1'b1; #1;
    check("wb_stall_pulse", {27'd0, state, reg_write}, {27'd0, 3'd4, 1'b0});
    tick();
    check("wb_stall_hold", {27'd0, state, reg_write}, {27'd0, 3'd4, 1'b0});
    stall = 1'b0; mem_ready = 1'b0; #1;
    check("wb_release", 32'(reg_write), 1);
    tick();
    check("wb_retired", {13'd0, state, retired}, {13'd0, 3'd0, 16'd1});

    // FETCH timeout follows the same rule
    repeat (11) tick();
    check("ftmo_still_fetch", 32'(state), 0);
    tick();
    check("ftmo_trap", {27'd0, state, trap, trap_cause}, {27'd0, 3'd6, 1'b1, 2'b10});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
